// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display logic: segment table,
// all-dark constants and the scan FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low a..g patterns; element k is the glyph for hex digit k.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31,
        7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C,
        7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Index of the most significant nonzero nibble; 0 when the word is zero,
    // so digit 0 always survives leading-zero suppression.
    function automatic logic [2:0] msd_index(input logic [31:0] word);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (word[i*4 +: 4] != 4'h0) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver with per-digit dead time
// and a once-per-frame snapshot of the displayed word and masks.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic        lz_en,
    output logic [6:0]  a2g,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    scan_state_t      state;
    scan_state_t      state_nx;

    logic [31:0]      data_s;
    logic [7:0]       dp_mask_s;
    logic [7:0]       blank_mask_s;
    logic             lz_en_s;
    logic [2:0]       msd_s;

    logic             phase_last;
    logic             frame_begin;
    logic [7:0][3:0]  nibbles;
    logic [3:0]       cur_nib;
    logic [6:0]       cur_seg;
    logic             suppress;

    logic [7:0]       an_nx;
    logic [6:0]       a2g_nx;
    logic             dp_nx;

    assign phase_last  = (cnt == CNT_LAST);
    assign frame_begin = (cnt == '0) && (idx == 3'd0);
    assign nibbles     = data_s;
    assign cur_nib     = nibbles[idx];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Phase counter, digit index and scan state; the first post-reset cycle
    // also sits at digit 0 / count 0, so it takes the opening snapshot.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt   <= '0;
            idx   <= 3'd0;
            state <= BLANK;
        end else begin
            cnt   <= phase_last ? '0 : cnt + 1'b1;
            state <= state_nx;
            if (phase_last) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BLANK:   if (cnt == DEAD_LAST) state_nx = SHOW;
            SHOW:    if (phase_last)       state_nx = BLANK;
            default: state_nx = BLANK;
        endcase
    end

    // Frame snapshot; the leading-digit index is computed once here so the
    // per-digit path only needs a 3-bit compare.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_s       <= 32'h0;
            dp_mask_s    <= 8'h0;
            blank_mask_s <= 8'h0;
            lz_en_s      <= 1'b0;
            msd_s        <= 3'd0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= frame_begin;
            if (frame_begin) begin
                data_s       <= data;
                dp_mask_s    <= dp_mask;
                blank_mask_s <= blank_mask;
                lz_en_s      <= lz_en;
                msd_s        <= msd_index(data);
            end
        end
    end

    assign suppress = blank_mask_s[idx] || (lz_en_s && (idx > msd_s));

    // A suppressed digit keeps its anode driven so the scan duty stays even;
    // only blank_mask darkens the decimal point.
    always_comb begin
        an_nx  = AN_OFF;
        a2g_nx = SEG_OFF;
        dp_nx  = 1'b1;
        if (state == SHOW) begin
            an_nx  = ~(8'b1 << idx);
            a2g_nx = suppress ? SEG_OFF : cur_seg;
            dp_nx  = blank_mask_s[idx] ? 1'b1 : ~dp_mask_s[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            an  <= AN_OFF;
            a2g <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nx;
            a2g <= a2g_nx;
            dp  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// input churn, compared every cycle against a position-based display model.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV    = 8;
    localparam int DEAD_CYCLES = 2;
    localparam int FRAME       = SCAN_DIV * 8;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] data = 32'h0;
    logic [7:0]  dpMask = 8'h0;
    logic [7:0]  blankMask = 8'h0;
    logic        lzEn = 1'b0;
    logic [6:0]  a2g;
    logic [7:0]  an;
    logic        dp;
    logic        frameStart;

    int errors = 0;
    int checks = 0;

    // Cycles elapsed since reset release, and the inputs latched for the frame.
    int          pos = 0;
    logic [31:0] mData = 32'h0;
    logic [7:0]  mDp = 8'h0;
    logic [7:0]  mBlank = 8'h0;
    logic        mLz = 1'b0;

    logic [6:0] segTable [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    seg7_scan_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .data        (data),
        .dp_mask     (dpMask),
        .blank_mask  (blankMask),
        .lz_en       (lzEn),
        .a2g         (a2g),
        .an          (an),
        .dp          (dp),
        .frame_start (frameStart)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int at, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at pos %0d: observed %h expected %h", tag, at, observed, expected);
        end
    endtask

    // Advance one clock per iteration; the display seen after the edge is the
    // scan position that was current just before it.
    task automatic applyStimulus(input int cycles);
        int q, c, d, top;
        logic inReset;
        logic [7:0] eAn;
        logic [6:0] eSeg;
        logic eDp, eFs;
        for (int n = 0; n < cycles; n++) begin
            inReset = clr;
            q = pos;
            if (inReset) begin
                pos = 0;
            end else begin
                if (q % FRAME == 0) begin
                    mData  = data;
                    mDp    = dpMask;
                    mBlank = blankMask;
                    mLz    = lzEn;
                end
                pos = pos + 1;
            end
            @(posedge clk);
            #1;
            eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1; eFs = 1'b0;
            if (!inReset) begin
                c = q % SCAN_DIV;
                d = (q / SCAN_DIV) % 8;
                eFs = (q % FRAME == 0);
                if (c >= DEAD_CYCLES) begin
                    top = 0;
                    for (int i = 0; i < 8; i++) if (((mData >> (4 * i)) & 32'hF) != 0) top = i;
                    eAn = ~(8'(1) << d);
                    if (mBlank[d] || (mLz && d > top)) eSeg = 7'h7F;
                    else eSeg = segTable[(mData >> (4 * d)) & 32'hF];
                    eDp = mBlank[d] ? 1'b1 : ~mDp[d];
                end
            end
            checkOutput("an", q, an, eAn);
            checkOutput("a2g", q, {1'b0, a2g}, {1'b0, eSeg});
            checkOutput("dp", q, {7'b0, dp}, {7'b0, eDp});
            checkOutput("frame_start", q, {7'b0, frameStart}, {7'b0, eFs});
        end
    endtask

    task automatic runToPos(input int target);
        for (int n = 0; n < FRAME && (pos % FRAME) != target; n++) applyStimulus(1);
    endtask

    initial begin
        $display("[TB] seg7_scan_driver SCAN_DIV=%0d DEAD_CYCLES=%0d", SCAN_DIV, DEAD_CYCLES);
        clr = 1'b1;
        data = 32'h76543210;
        applyStimulus(3);
        clr = 1'b0;
        applyStimulus(FRAME + SCAN_DIV);

        runToPos(0);
        data = 32'h0000_00A0; lzEn = 1'b1;
        applyStimulus(FRAME);
        data = 32'h0;
        applyStimulus(FRAME);

        dpMask = 8'h05; blankMask = 8'h80; data = 32'h89AB_CDEF; lzEn = 1'b0;
        applyStimulus(FRAME);

        dpMask = 8'h00; blankMask = 8'h00;
        data = 32'h1111_1111;
        applyStimulus(FRAME);
        runToPos(3 * SCAN_DIV + DEAD_CYCLES + 1);
        data = 32'h2222_2222;
        applyStimulus(2 * FRAME);

        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                data      = $urandom >> (4 * $urandom_range(0, 8));
                dpMask    = 8'($urandom);
                blankMask = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                lzEn      = 1'($urandom);
            end
            applyStimulus(1);
        end

        runToPos(5 * SCAN_DIV + DEAD_CYCLES + 2);
        clr = 1'b1;
        data = 32'hFEDC_BA98; dpMask = 8'hF0; blankMask = 8'h00; lzEn = 1'b0;
        applyStimulus(2);
        clr = 1'b0;
        applyStimulus(FRAME + SCAN_DIV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
